// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus widths, decode-bundle layout, ALU/divider op bit indices
// and divider state encoding shared by the LoongArch32 execute stage.
`default_nettype none
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD = 152;
  localparam int ES_TO_MS_BUS_WD = 72;

  // alu_op one-hot bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // div_op bit positions
  localparam int DIV_EN     = 2;
  localparam int DIV_SIGNED = 1;
  localparam int DIV_REM    = 0;

  typedef struct packed {
    logic [2:0]  div_op;
    logic [11:0] alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] rkd_value;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic        inst_no_dest;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
endpackage
`default_nettype wire

// File: rtl/exe_stage_div_iter.sv
// div_iter: iterative restoring radix-2 32-bit divider, one quotient bit per
// cycle on magnitudes, with sign fix-up applied to the held result.
`default_nettype none
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        sign,
  input  logic        rem,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  div_state_e  state, state_nxt;
  logic [31:0] quo, rmd, dsr;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, rem_sel;
  logic [32:0] rmd_shift;
  logic        fits;

  // Dividend bits are shifted out of quo into the partial remainder.
  assign rmd_shift = {rmd, quo[31]};
  assign fits      = rmd_shift >= {1'b0, dsr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start)        state_nxt = DIV_CALC;
      DIV_CALC: if (cnt == 5'd31) state_nxt = DIV_DONE;
      DIV_DONE: if (ack)          state_nxt = DIV_IDLE;
      default:                    state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo     <= '0;
      rmd     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
    end else if (state == DIV_IDLE && start) begin
      quo     <= (sign && dividend[31]) ? -dividend : dividend;
      dsr     <= (sign && divisor[31])  ? -divisor  : divisor;
      rmd     <= '0;
      cnt     <= '0;
      neg_q   <= sign && (dividend[31] ^ divisor[31]);
      neg_r   <= sign && dividend[31];
      rem_sel <= rem;
    end else if (state == DIV_CALC) begin
      rmd <= fits ? (rmd_shift[31:0] - dsr) : rmd_shift[31:0];
      quo <= {quo[30:0], fits};
      cnt <= cnt + 5'd1;
    end
  end

  assign busy   = (state == DIV_CALC);
  assign done   = (state == DIV_DONE);
  assign result = !done   ? 32'd0 :
                  rem_sel ? (neg_r ? -rmd : rmd) :
                            (neg_q ? -quo : quo);
endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
// exe_stage: LoongArch32 execute stage (ALU, optional iterative divider when
// MYCPU_DIV_EN is defined, data-SRAM request, forwarding view for decode).
`default_nettype none
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [4:0]                 es_to_ds_dest,
  output logic                       es_to_ds_load,
  output logic [31:0]                es_to_ds_result,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  logic        es_valid;
  logic        es_ready_go;
  ds_to_es_t   bus_q;
  logic        is_div;
  logic [31:0] src1, src2;
  logic [31:0] sum, diff, alu_result, final_result;
  logic        slt_res, sltu_res;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
      bus_q    <= '0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) bus_q <= ds_to_es_bus;
    end
  end

  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  assign src1     = bus_q.alu_src1;
  assign src2     = bus_q.alu_src2;
  assign is_div   = bus_q.div_op[DIV_EN];
  assign sum      = src1 + src2;
  assign diff     = src1 - src2;
  assign slt_res  = $signed(src1) < $signed(src2);
  assign sltu_res = src1 < src2;

  assign alu_result = ({32{bus_q.alu_op[ALU_ADD]}}  & sum)
                    | ({32{bus_q.alu_op[ALU_SUB]}}  & diff)
                    | ({32{bus_q.alu_op[ALU_SLT]}}  & {31'd0, slt_res})
                    | ({32{bus_q.alu_op[ALU_SLTU]}} & {31'd0, sltu_res})
                    | ({32{bus_q.alu_op[ALU_AND]}}  & (src1 & src2))
                    | ({32{bus_q.alu_op[ALU_NOR]}}  & ~(src1 | src2))
                    | ({32{bus_q.alu_op[ALU_OR]}}   & (src1 | src2))
                    | ({32{bus_q.alu_op[ALU_XOR]}}  & (src1 ^ src2))
                    | ({32{bus_q.alu_op[ALU_SLL]}}  & (src1 << src2[4:0]))
                    | ({32{bus_q.alu_op[ALU_SRL]}}  & (src1 >> src2[4:0]))
                    | ({32{bus_q.alu_op[ALU_SRA]}}  & $unsigned($signed(src1) >>> src2[4:0]))
                    | ({32{bus_q.alu_op[ALU_LUI]}}  & src2);

`ifdef MYCPU_DIV_EN
  logic        div_busy, div_done;
  logic [31:0] div_result;

  // Start only while the divider holds nothing, so a stalled DONE never restarts.
  div_iter u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (es_valid && is_div && !div_busy && !div_done),
    .sign     (bus_q.div_op[DIV_SIGNED]),
    .rem      (bus_q.div_op[DIV_REM]),
    .dividend (src1),
    .divisor  (src2),
    .ack      (es_valid && ms_allowin),
    .busy     (div_busy),
    .done     (div_done),
    .result   (div_result)
  );

  assign es_ready_go  = is_div ? div_done : 1'b1;
  assign final_result = is_div ? div_result : alu_result;
`else
  logic unused_div_mode;
  assign unused_div_mode = ^bus_q.div_op[1:0];
  assign es_ready_go     = 1'b1;
  assign final_result    = is_div ? 32'd0 : alu_result;
`endif

  assign es_to_ms_bus = {bus_q.res_from_mem, bus_q.gr_we, bus_q.dest,
                         final_result, bus_q.pc, bus_q.inst_no_dest};

  assign es_to_ds_dest   = (es_valid && !bus_q.inst_no_dest) ? bus_q.dest : 5'd0;
  assign es_to_ds_load   = es_valid && bus_q.res_from_mem;
  assign es_to_ds_result = final_result;

  // Memory ops always have ready_go high, so the request fires on the leaving edge only.
  assign data_sram_en    = es_valid && (bus_q.res_from_mem || bus_q.mem_we) && ms_allowin;
  assign data_sram_we    = {4{bus_q.mem_we && es_valid}};
  assign data_sram_addr  = sum;
  assign data_sram_wdata = bus_q.rkd_value;
endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage; divider expectations
// follow whether MYCPU_DIV_EN is defined for the build.
`default_nettype none
module tb_exe_stage;
  import exe_stage_pkg::*;

`ifdef MYCPU_DIV_EN
  localparam bit DIV_ON  = 1'b1;
  localparam int DIV_LAT = 33;
`else
  localparam bit DIV_ON  = 1'b0;
  localparam int DIV_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [151:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [71:0]  es_to_ms_bus;
  logic [4:0]   es_to_ds_dest;
  logic         es_to_ds_load;
  logic [31:0]  es_to_ds_result;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int total = 0;
  int bad   = 0;

  exe_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_dest   (es_to_ds_dest),
    .es_to_ds_load   (es_to_ds_load),
    .es_to_ds_result (es_to_ds_result),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [151:0] mk(input logic [2:0] dop, input logic [11:0] aop,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic mwe,
                                      input logic rfm, input logic gwe,
                                      input logic [4:0] dst, input logic nod,
                                      input logic [31:0] pc);
    ds_to_es_t b;
    b.div_op       = dop;
    b.alu_op       = aop;
    b.alu_src1     = s1;
    b.alu_src2     = s2;
    b.rkd_value    = rkd;
    b.mem_we       = mwe;
    b.res_from_mem = rfm;
    b.gr_we        = gwe;
    b.dest         = dst;
    b.inst_no_dest = nod;
    b.pc           = pc;
    return b;
  endfunction

  // Entry edge of the div already on the bus, then count edges until ready_go.
  task automatic run_div(input string tag, input logic [31:0] exp,
                         input logic [151:0] nbus, input logic nvalid, input logic nallow);
    int n;
    @(posedge clk); #1;
    ds_to_es_bus   = nbus;
    ds_to_es_valid = nvalid;
    ms_allowin     = nallow;
    n = 0;
    while (!es_to_ms_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 72'(n), 72'(DIV_LAT));
    chk({tag, "_result"}, 72'(es_to_ds_result), 72'(DIV_ON ? exp : 32'd0));
  endtask

  localparam logic [11:0] OP_ADD  = 12'd1 << ALU_ADD;
  localparam logic [11:0] OP_SLT  = 12'd1 << ALU_SLT;
  localparam logic [11:0] OP_SLTU = 12'd1 << ALU_SLTU;

  initial begin
    resetn         = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allowin", 72'(es_allowin), 72'(1));
    chk("rst_ms_valid", 72'(es_to_ms_valid), 72'(0));
    chk("rst_ms_bus", es_to_ms_bus, 72'(0));
    chk("rst_sram", {data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}, 72'(0));
    chk("rst_fwd", {es_to_ds_dest, es_to_ds_load, es_to_ds_result}, 72'(0));
    resetn = 1'b1;

    // add 5 + 7 then sltu / slt on 0xFFFFFFFF vs 1
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(3'b000, OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 32'h1c000000);
    @(posedge clk); #1;
    chk("add_valid", 72'(es_to_ms_valid), 72'(1));
    chk("add_bus", es_to_ms_bus, {1'b0, 1'b1, 5'd3, 32'd12, 32'h1c000000, 1'b0});
    chk("add_fwd_dest", 72'(es_to_ds_dest), 72'(3));
    ds_to_es_bus = mk(3'b000, OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h1c000004);
    @(posedge clk); #1;
    chk("sltu_valid", 72'(es_to_ms_valid), 72'(1));
    chk("sltu_result", 72'(es_to_ds_result), 72'(0));
    ds_to_es_bus = mk(3'b000, OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h1c000008);
    @(posedge clk); #1;
    chk("slt_result", 72'(es_to_ds_result), 72'(1));

    // Back-to-back divides: div.w -7/2, mod.w -7/2, div.wu 100/0, div.w 0x80000000/-1
    ds_to_es_bus = mk(3'b110, 12'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0, 32'h1c00000c);
    run_div("div_w", 32'hFFFFFFFD,
            mk(3'b111, 12'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 32'h1c000010), 1'b1, 1'b1);
    run_div("mod_w", 32'hFFFFFFFF,
            mk(3'b100, 12'd0, 32'd100, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 32'h1c000014), 1'b1, 1'b1);
    run_div("divu_by0", 32'hFFFFFFFF,
            mk(3'b110, 12'd0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h1c000018), 1'b1, 1'b1);
    run_div("div_ovf", 32'h80000000, '0, 1'b0, 1'b0);

    // Held while ms_allowin is low
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", 72'(es_to_ms_valid), 72'(1));
    chk("hold_result", 72'(es_to_ds_result), 72'(DIV_ON ? 32'h80000000 : 32'd0));
    chk("hold_allowin", 72'(es_allowin), 72'(0));
    ms_allowin = 1'b1;
    #1;
    chk("release_allowin", 72'(es_allowin), 72'(1));
    @(posedge clk); #1;
    chk("drained_valid", 72'(es_to_ms_valid), 72'(0));

    // Store stalled by ms_allowin for 3 cycles
    ms_allowin     = 1'b0;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(3'b000, OP_ADD, 32'h100, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1c000020);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("st_stall_en", 72'(data_sram_en), 72'(0));
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    ms_allowin = 1'b1;
    #1;
    chk("st_req", {data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata},
        {1'b1, 4'hF, 32'h108, 32'hDEADBEEF});
    @(posedge clk); #1;
    chk("st_single_pulse", 72'(data_sram_en), 72'(0));

    // Load forwarding view, then a no-dest instruction
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(3'b000, OP_ADD, 32'h200, 32'h4, 32'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 32'h1c000024);
    @(posedge clk); #1;
    chk("ld_fwd", {es_to_ds_load, es_to_ds_dest}, {1'b1, 5'd7});
    chk("ld_req", {data_sram_en, data_sram_we, data_sram_addr}, {1'b1, 4'h0, 32'h204});
    ds_to_es_bus = mk(3'b000, OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 32'h1c000028);
    @(posedge clk); #1;
    chk("nodest_fwd", {es_to_ds_load, es_to_ds_dest}, {1'b0, 5'd0});

    // Reset in the middle of a divide
    ds_to_es_bus = mk(3'b100, 12'd0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 32'h1c00002c);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_state", {es_to_ms_valid, es_allowin, data_sram_en, es_to_ds_result},
        {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'd0});
    @(posedge clk); #1;
    resetn         = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(3'b000, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 32'h1c000030);
    @(posedge clk); #1;
    chk("post_rst_add", {es_to_ms_valid, es_to_ds_result}, {1'b1, 32'd3});
    ds_to_es_bus = mk(3'b100, 12'd0, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 32'h1c000034);
    run_div("post_rst_divu", 32'd14, '0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
